// File: rtl/rmt_ctrl_pkg.sv
// Shared types, default widths and helpers for the RMT stage control blocks.
package rmt_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } arb_state_e;

    localparam int PHV_LEN_DEF = 1024;
    localparam int ACT_LEN_DEF = 25;
    localparam int ACT_NUM_DEF = 25;
    localparam int N_REQ_MAX   = 4;

    // Index to one-hot; callers truncate to their own requester count.
    function automatic logic [N_REQ_MAX-1:0] onehot(input logic [1:0] idx);
        logic [N_REQ_MAX-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/action_engine_arbiter_tag_fifo.sv
// In-order FIFO of requester tags, one entry per PHV currently inside the engine.
module tag_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    // Storage needs no reset; only entries behind the write pointer are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: ;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (count == '0);
    assign full     = (count == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/action_engine_arbiter.sv
// Round-robin arbiter sharing one action engine between N_REQ sources,
// with bounded in-flight traffic, in-order result steering and halt/drain.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_RUN   | normal operation, grants allowed
//   ST_DRAIN | halt requested, no grants, waiting for in-flight to reach 0
//   ST_HALT  | engine idle and quiescent, safe to reconfigure; halted=1
module action_engine_arbiter
    import rmt_ctrl_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int PHV_LEN      = PHV_LEN_DEF,
    parameter int ACT_LEN      = ACT_LEN_DEF,
    parameter int ACT_NUM      = ACT_NUM_DEF,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [N_REQ*PHV_LEN-1:0]           req_phv,
    input  logic [N_REQ-1:0]                   req_phv_valid,
    input  logic [N_REQ*ACT_LEN*ACT_NUM-1:0]   req_action,
    input  logic [N_REQ-1:0]                   req_action_valid,
    output logic [N_REQ-1:0]                   req_ready,
    output logic [PHV_LEN-1:0]                 eng_phv,
    output logic                               eng_phv_valid,
    output logic [ACT_LEN*ACT_NUM-1:0]         eng_action,
    output logic                               eng_action_valid,
    input  logic                               eng_ready,
    input  logic [PHV_LEN-1:0]                 eng_res_phv,
    input  logic                               eng_res_valid,
    output logic [PHV_LEN-1:0]                 res_phv,
    output logic [N_REQ-1:0]                   res_valid,
    input  logic                               cfg_halt,
    output logic                               halted,
    output logic [$clog2(MAX_INFLIGHT):0]      inflight_cnt,
    output logic                               err_orphan
);
    localparam int ACT_W = ACT_LEN * ACT_NUM;
    localparam int TAG_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
    localparam logic [TAG_W:0]   NREQ_W  = (TAG_W+1)'(N_REQ);

    arb_state_e       state;
    arb_state_e       state_nxt;
    logic             run_en;
    logic [N_REQ-1:0] active;
    logic             issue_ok;
    logic             grant_any;
    logic [TAG_W-1:0] grant_idx;
    logic [TAG_W-1:0] rr_ptr;
    logic [TAG_W:0]   cand;
    logic [TAG_W:0]   ptr_inc;
    logic             fifo_push;
    logic             fifo_pop;
    logic [TAG_W-1:0] fifo_tag;
    logic             fifo_empty;
    logic             fifo_full;

    // A source only counts as requesting when both its PHV and action are valid.
    assign active   = req_phv_valid & req_action_valid;
    // Count is compared before this cycle's pop, so a pop at full never frees a slot early.
    assign issue_ok = run_en && eng_ready && (inflight_cnt < CNT_MAX);

    // First active requester at or after rr_ptr; scanning downward lets the nearest win.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = rr_ptr;
        cand      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (TAG_W+1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (issue_ok && active[cand[TAG_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[TAG_W-1:0];
            end
        end
    end

    // Pointer moves to the slot after the winner, wrapping at N_REQ.
    always_comb begin
        ptr_inc = {1'b0, grant_idx} + (TAG_W+1)'(1);
        if (ptr_inc >= NREQ_W) begin
            ptr_inc = '0;
        end
    end

    assign req_ready = grant_any ? N_REQ'(onehot(2'(grant_idx))) : '0;

    // Round-robin pointer, updated only on a grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= ptr_inc[TAG_W-1:0];
        end
    end

    // Issue register toward the engine; data holds when nothing is granted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            eng_phv       <= '0;
            eng_action    <= '0;
            eng_phv_valid <= 1'b0;
        end else begin
            eng_phv_valid <= grant_any;
            if (grant_any) begin
                eng_phv    <= req_phv[grant_idx*PHV_LEN +: PHV_LEN];
                eng_action <= req_action[grant_idx*ACT_W +: ACT_W];
            end
        end
    end

    assign eng_action_valid = eng_phv_valid;

    // A result with no recorded tag is an orphan and must not pop the FIFO.
    assign fifo_push = grant_any && !fifo_full;
    assign fifo_pop  = eng_res_valid && !fifo_empty;

    tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (grant_idx),
        .pop       (fifo_pop),
        .pop_data  (fifo_tag),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Return path: steer each result to the requester recorded at issue time.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_phv    <= '0;
            res_valid  <= '0;
            err_orphan <= 1'b0;
        end else begin
            res_valid <= '0;
            if (fifo_pop) begin
                res_phv   <= eng_res_phv;
                res_valid <= N_REQ'(onehot(2'(fifo_tag)));
            end
            if (eng_res_valid && fifo_empty) begin
                err_orphan <= 1'b1;
            end
        end
    end

    // In-flight counter; a grant and a pop in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight_cnt <= '0;
        end else begin
            case ({grant_any, fifo_pop})
                2'b10:   inflight_cnt <= inflight_cnt + CNT_W'(1);
                2'b01:   inflight_cnt <= inflight_cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; dropping cfg_halt always returns straight to RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (cfg_halt) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!cfg_halt) begin
                    state_nxt = ST_RUN;
                end else if (inflight_cnt == '0) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (!cfg_halt) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // FSM outputs, decoded from the state register only.
    always_comb begin
        run_en = (state == ST_RUN);
        halted = (state == ST_HALT);
    end

endmodule

// File: tb/tb_action_engine_arbiter.sv
// Scoreboard bench for action_engine_arbiter with a small in-order engine model.
module tb_action_engine_arbiter;
    localparam int N_REQ        = 2;
    localparam int PHV_LEN      = 1024;
    localparam int ACT_LEN      = 25;
    localparam int ACT_NUM      = 25;
    localparam int MAX_INFLIGHT = 8;
    localparam int ACT_W        = ACT_LEN * ACT_NUM;
    localparam int CNT_W        = $clog2(MAX_INFLIGHT) + 1;
    localparam int ENG_LAT      = 3;
    localparam logic [PHV_LEN-1:0] RES_MASK = {32{32'h5A5A_5A5A}};

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [N_REQ*PHV_LEN-1:0] req_phv;
    logic [N_REQ-1:0]         req_phv_valid;
    logic [N_REQ*ACT_W-1:0]   req_action;
    logic [N_REQ-1:0]         req_action_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [PHV_LEN-1:0]       eng_phv;
    logic                     eng_phv_valid;
    logic [ACT_W-1:0]         eng_action;
    logic                     eng_action_valid;
    logic                     eng_ready;
    logic [PHV_LEN-1:0]       eng_res_phv;
    logic                     eng_res_valid;
    logic [PHV_LEN-1:0]       res_phv;
    logic [N_REQ-1:0]         res_valid;
    logic                     cfg_halt;
    logic                     halted;
    logic [CNT_W-1:0]         inflight_cnt;
    logic                     err_orphan;

    int n_checks = 0;
    int n_fail   = 0;
    int grant_q[$];
    int issue_q[$];
    int res_q[$];
    logic [PHV_LEN-1:0] eq_data[$];
    int eq_cyc[$];
    int eng_cyc;
    int eng_stall;
    int release_cnt;
    int mon_g;

    always #5 clk = ~clk;

    action_engine_arbiter #(
        .N_REQ        (N_REQ),
        .PHV_LEN      (PHV_LEN),
        .ACT_LEN      (ACT_LEN),
        .ACT_NUM      (ACT_NUM),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_phv          (req_phv),
        .req_phv_valid    (req_phv_valid),
        .req_action       (req_action),
        .req_action_valid (req_action_valid),
        .req_ready        (req_ready),
        .eng_phv          (eng_phv),
        .eng_phv_valid    (eng_phv_valid),
        .eng_action       (eng_action),
        .eng_action_valid (eng_action_valid),
        .eng_ready        (eng_ready),
        .eng_res_phv      (eng_res_phv),
        .eng_res_valid    (eng_res_valid),
        .res_phv          (res_phv),
        .res_valid        (res_valid),
        .cfg_halt         (cfg_halt),
        .halted           (halted),
        .inflight_cnt     (inflight_cnt),
        .err_orphan       (err_orphan)
    );

    function automatic logic [PHV_LEN-1:0] phv_pat(input int i);
        return {32{32'hC0DE_0000 + 32'(i)}};
    endfunction

    function automatic logic [ACT_W-1:0] act_pat(input int i);
        return {25{25'h1A5_A000 + 25'(i)}};
    endfunction

    task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (low 64 bits)", name, act[63:0], exp[63:0]);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: output asserted with nothing expected", name);
    endtask

    task automatic set_req(input logic [1:0] pv, input logic [1:0] av);
        req_phv_valid    = pv;
        req_action_valid = av;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (inflight_cnt != '0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(name, 1024'(inflight_cnt), 1024'(0));
        repeat (2) @(negedge clk);
    endtask

    // Engine model: in-order, fixed latency, optionally stalled with single-step release.
    initial begin
        eng_cyc       = 0;
        eng_res_valid = 1'b0;
        eng_res_phv   = '0;
        forever begin
            @(negedge clk);
            eng_cyc++;
            if (eng_phv_valid) begin
                eq_data.push_back(eng_phv);
                eq_cyc.push_back(eng_cyc);
            end
            if (eq_data.size() > 0 && (eng_cyc - eq_cyc[0]) >= ENG_LAT &&
                (eng_stall == 0 || release_cnt > 0)) begin
                if (eng_stall != 0) release_cnt--;
                eng_res_valid = 1'b1;
                eng_res_phv   = eq_data.pop_front() ^ RES_MASK;
                void'(eq_cyc.pop_front());
            end else begin
                eng_res_valid = 1'b0;
            end
        end
    end

    // Monitor: grants, issues and results are popped from the scoreboard as they appear.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (eng_phv_valid) begin
                    if (issue_q.size() == 0) unexpected("issue_unexpected");
                    else begin
                        mon_g = issue_q.pop_front();
                        chk("issue_phv", 1024'(eng_phv), 1024'(phv_pat(mon_g)));
                        chk("issue_action", 1024'(eng_action), 1024'(act_pat(mon_g)));
                        chk("issue_action_valid", 1024'(eng_action_valid), 1024'(1));
                    end
                end
                if (req_ready != '0) begin
                    if (grant_q.size() == 0) unexpected("grant_unexpected");
                    else begin
                        mon_g = grant_q.pop_front();
                        chk("grant", 1024'(req_ready), 1024'(1 << mon_g));
                        issue_q.push_back(mon_g);
                        res_q.push_back(mon_g);
                    end
                end
                if (res_valid != '0) begin
                    if (res_q.size() == 0) unexpected("result_unexpected");
                    else begin
                        mon_g = res_q.pop_front();
                        chk("res_valid", 1024'(res_valid), 1024'(1 << mon_g));
                        chk("res_phv", 1024'(res_phv), 1024'(phv_pat(mon_g) ^ RES_MASK));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        cfg_halt    = 1'b0;
        eng_ready   = 1'b1;
        eng_stall   = 0;
        release_cnt = 0;
        req_phv     = {phv_pat(1), phv_pat(0)};
        req_action  = {act_pat(1), act_pat(0)};
        set_req(2'b00, 2'b00);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", 1024'(req_ready), 1024'(0));
        chk("reset_eng_valid", 1024'(eng_phv_valid), 1024'(0));
        chk("reset_res_valid", 1024'(res_valid), 1024'(0));
        chk("reset_inflight", 1024'(inflight_cnt), 1024'(0));
        chk("reset_halted", 1024'(halted), 1024'(0));
        chk("reset_orphan", 1024'(err_orphan), 1024'(0));

        // Round robin with both sources active: 0,1,0,1.
        @(posedge clk); #1;
        set_req(2'b11, 2'b11);
        grant_q.push_back(0); grant_q.push_back(1);
        grant_q.push_back(0); grant_q.push_back(1);
        repeat (4) @(posedge clk);
        #1 set_req(2'b00, 2'b00);
        wait_idle("rr_drain");

        // Half-valid requester 0 is never granted; requester 1 wins every cycle.
        @(posedge clk); #1;
        set_req(2'b11, 2'b10);
        grant_q.push_back(1); grant_q.push_back(1); grant_q.push_back(1);
        repeat (3) @(posedge clk);
        #1 set_req(2'b00, 2'b01);
        @(negedge clk);
        chk("action_only_no_grant", 1024'(req_ready), 1024'(0));
        @(posedge clk); #1;
        set_req(2'b11, 2'b11);
        eng_ready = 1'b0;
        @(negedge clk);
        chk("eng_not_ready_no_grant", 1024'(req_ready), 1024'(0));
        @(posedge clk); #1;
        set_req(2'b00, 2'b00);
        eng_ready = 1'b1;
        wait_idle("partial_drain");

        // In-flight limit: 8 grants, then the 9th only after a result is consumed.
        eng_stall = 1;
        @(posedge clk); #1;
        set_req(2'b01, 2'b01);
        for (int i = 0; i < 8; i++) grant_q.push_back(0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("full_inflight", 1024'(inflight_cnt), 1024'(8));
        chk("full_no_grant", 1024'(req_ready), 1024'(0));
        @(posedge clk); #1;
        release_cnt = 1;
        @(negedge clk);
        chk("release_cycle_no_grant", 1024'(req_ready), 1024'(0));
        chk("release_cycle_eng_res", 1024'(eng_res_valid), 1024'(1));
        @(posedge clk); #1;
        grant_q.push_back(0);
        @(negedge clk);
        chk("ninth_grant", 1024'(req_ready), 1024'(2'b01));
        chk("ninth_inflight", 1024'(inflight_cnt), 1024'(7));
        @(posedge clk); #1;
        set_req(2'b00, 2'b00);
        @(negedge clk);
        chk("refull_inflight", 1024'(inflight_cnt), 1024'(8));

        // Grant and pop in the same cycle at count 5.
        @(posedge clk); #1;
        release_cnt = 3;
        repeat (4) @(negedge clk);
        chk("count_five", 1024'(inflight_cnt), 1024'(5));
        @(posedge clk); #1;
        set_req(2'b10, 2'b10);
        release_cnt = 1;
        grant_q.push_back(1);
        @(posedge clk); #1;
        set_req(2'b00, 2'b00);
        @(negedge clk);
        chk("simul_count", 1024'(inflight_cnt), 1024'(5));
        eng_stall = 0;
        wait_idle("simul_drain");

        // Halt/drain: third grant lands in the cycle cfg_halt rises, then nothing.
        eng_stall = 1;
        @(posedge clk); #1;
        set_req(2'b11, 2'b11);
        grant_q.push_back(0); grant_q.push_back(1); grant_q.push_back(0);
        @(posedge clk);
        @(posedge clk); #1;
        cfg_halt = 1'b1;
        repeat (5) @(negedge clk);
        chk("drain_inflight", 1024'(inflight_cnt), 1024'(3));
        chk("drain_not_halted", 1024'(halted), 1024'(0));
        chk("drain_no_grant", 1024'(req_ready), 1024'(0));
        @(posedge clk); #1;
        eng_stall = 0;
        begin
            int n;
            n = 0;
            while (inflight_cnt != '0 && n < 30) begin
                @(negedge clk);
                n++;
            end
        end
        chk("halt_wait", 1024'(inflight_cnt), 1024'(0));
        chk("halt_last_result", 1024'(res_valid), 1024'(2'b01));
        chk("halt_not_yet", 1024'(halted), 1024'(0));
        @(negedge clk);
        chk("halted_set", 1024'(halted), 1024'(1));
        @(posedge clk); #1;
        cfg_halt = 1'b0;
        grant_q.push_back(1); grant_q.push_back(0);
        @(negedge clk);
        chk("resume_cycle_no_grant", 1024'(req_ready), 1024'(0));
        chk("resume_cycle_halted", 1024'(halted), 1024'(1));
        @(negedge clk);
        chk("resume_grant_rr", 1024'(req_ready), 1024'(2'b10));
        chk("resume_halted_low", 1024'(halted), 1024'(0));
        @(posedge clk);
        @(posedge clk); #1;
        set_req(2'b00, 2'b00);
        wait_idle("resume_drain");

        // Reset with two in flight; their results become orphans.
        eng_stall = 1;
        @(posedge clk); #1;
        set_req(2'b01, 2'b01);
        grant_q.push_back(0); grant_q.push_back(0);
        @(posedge clk);
        @(posedge clk); #1;
        set_req(2'b00, 2'b00);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        grant_q.delete();
        issue_q.delete();
        res_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_inflight", 1024'(inflight_cnt), 1024'(0));
        chk("rst2_orphan", 1024'(err_orphan), 1024'(0));
        @(posedge clk); #1;
        release_cnt = 1;
        @(negedge clk);
        @(negedge clk);
        chk("orphan_set", 1024'(err_orphan), 1024'(1));
        chk("orphan_no_res", 1024'(res_valid), 1024'(0));
        @(posedge clk); #1;
        release_cnt = 1;
        @(negedge clk);
        @(negedge clk);
        chk("orphan_sticky", 1024'(err_orphan), 1024'(1));
        chk("orphan2_no_res", 1024'(res_valid), 1024'(0));
        chk("orphan_inflight", 1024'(inflight_cnt), 1024'(0));
        eng_stall = 0;
        repeat (3) @(negedge clk);

        chk("grant_q_empty", 1024'(grant_q.size()), 1024'(0));
        chk("res_q_empty", 1024'(res_q.size()), 1024'(0));
        chk("engine_empty", 1024'(eq_data.size()), 1024'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/action_engine_arbiter.md
Name: action_engine_arbiter

Overview:
- Shares one action engine between N_REQ upstream PHV+action sources, e.g. per-tenant lookup pipes feeding one stage.
- Grants round-robin, issues one PHV/action pair per cycle into the engine, and bounds in-flight traffic with a counter.
- Records each grant in an in-order tag FIFO and steers each engine result back to its originating requester.
- Provides a halt/drain sequence so control software can reconfigure the engine (stateful ALU tables) with no traffic in flight.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- PHV_LEN, 1024, PHV width (48*8+32*8+16*8+256).
- ACT_LEN, 25, width of one sub-action.
- ACT_NUM, 25, sub-actions per action word; action bus width = ACT_LEN*ACT_NUM.
- MAX_INFLIGHT, 8, maximum issued-but-not-returned PHVs; power of 2; also the tag FIFO depth.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_phv  in  N_REQ*PHV_LEN  per-requester PHV; requester i occupies slice i.
- req_phv_valid  in  N_REQ  per-requester PHV valid.
- req_action  in  N_REQ*ACT_LEN*ACT_NUM  per-requester action word.
- req_action_valid  in  N_REQ  per-requester action valid.
- req_ready  out  N_REQ  one-hot; the grant this cycle.
- eng_phv  out  PHV_LEN  PHV to engine.
- eng_phv_valid  out  1  PHV valid to engine.
- eng_action  out  ACT_LEN*ACT_NUM  action to engine.
- eng_action_valid  out  1  action valid to engine; equals eng_phv_valid.
- eng_ready  in  1  engine ready.
- eng_res_phv  in  PHV_LEN  engine result PHV.
- eng_res_valid  in  1  engine result valid.
- res_phv  out  PHV_LEN  result PHV, shared bus for all requesters.
- res_valid  out  N_REQ  one-hot; marks the destination of res_phv.
- cfg_halt  in  1  level; requests halt.
- halted  out  1  high when halted with zero in flight.
- inflight_cnt  out  $clog2(MAX_INFLIGHT)+1  current in-flight count.
- err_orphan  out  1  sticky; set when a result arrives with the tag FIFO empty.

Behaviour:
- Reset: all outputs 0, rr_ptr=0, FIFO empty, count 0, state RUN. A reset mid-operation discards in-flight tags; results arriving afterwards raise err_orphan.
- Request: req i is active when req_phv_valid[i] && req_action_valid[i]. Valid on only one of the two is not a request and is never granted.
- Issue condition: state==RUN, eng_ready, inflight_cnt<MAX_INFLIGHT, and at least one request active.
- Grant selection: the first active request searching from rr_ptr upward with wrap-around.
- req_ready is combinational, one-hot at most, and only asserted when the issue condition holds.
- On a grant g, rr_ptr <= (g+1) mod N_REQ. rr_ptr is unchanged when nothing is granted.
- Issue latency: 1 cycle. On a grant, eng_phv/eng_action are registered from slice g and eng_*_valid=1 the next cycle. Otherwise valid=0 and data holds its last value.
- Tag FIFO: on a grant, push g. On eng_res_valid, pop.
- Return path: res_phv <= eng_res_phv and res_valid <= onehot(popped tag), registered (1 cycle). The engine is in-order, so FIFO order matches result order.
- Orphan result: a result arriving with the FIFO empty is dropped, with res_valid=0 and err_orphan set until reset.
- inflight_cnt: +1 on grant, -1 on a valid pop. A simultaneous grant and pop leaves it unchanged.
- Full condition: at count==MAX_INFLIGHT no grant is issued; a pop in the same cycle does not enable a grant (the count is compared before update).
- State machine:
  - RUN: if cfg_halt, go to DRAIN; grants are still allowed in that cycle.
  - DRAIN: no grants. When inflight_cnt==0, go to HALT.
  - HALT: halted=1 (registered, asserted in the HALT state). When cfg_halt deasserts, go to RUN; halted drops in that same transition.
- cfg_halt deasserted during DRAIN: return to RUN immediately.
- Result returns continue normally in all states.

Decomposition:
- Shared package `rmt_ctrl_pkg`: state encoding (RUN=2'd0, DRAIN=2'd1, HALT=2'd2), the default PHV_LEN/ACT_LEN/ACT_NUM constants, and a onehot function.
- One sub-module `tag_fifo`: synchronous FIFO of width $clog2(N_REQ) and depth MAX_INFLIGHT, with push/pop/empty/full. A simultaneous push and pop on an empty FIFO is not allowed; the count logic guarantees a pop only occurs with a tag present.

Test Plan:
- Round-robin fairness: N_REQ=2, both requesters continuously active, eng_ready=1 → grants alternate 0,1,0,1. Engine with fixed 3-cycle latency → res_valid sequence 01,10,01,10, each result matching its requester's PHV.
- Partial request: req0 has phv_valid=1 and action_valid=0; req1 fully active → only req1 granted; req_ready[0] never asserted.
- Full in-flight limit: engine result path stalled, 9 requests offered → exactly 8 grants and inflight_cnt=8. Release one result → the 9th grant occurs in the following cycle, not the release cycle.
- Simultaneous issue and return: grant and result in the same cycle at count=5 → count stays 5, FIFO order preserved.
- Halt/drain: assert cfg_halt with 3 in flight → no further grants; halted=1 one cycle after the third result returns. Deassert cfg_halt → grants resume next cycle with the preserved rr_ptr.
- Orphan and reset: reset with 2 in flight, then 2 results arrive → no res_valid; err_orphan=1 after the first result.
